// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases sys_rstn.
// Optional macro RESET_SEQ_GLITCH_FILTER_EN ignores short lock dropouts in HOLD/RUN.
`timescale 1ns/1ps
module pll_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 1024,
    parameter int LOCK_TIMEOUT   = 1000000,
    parameter int PLL_RST_CYCLES = 16,
    parameter int GLITCH_CYCLES  = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       pll_rst,
    output logic       sys_rstn,
    output logic [1:0] state,
    output logic [7:0] relock_cnt
);

    localparam int CNT_MAX_A = (HOLD_CYCLES > LOCK_TIMEOUT) ? HOLD_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX   = (CNT_MAX_A > PLL_RST_CYCLES) ? CNT_MAX_A : PLL_RST_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'b00,
        WAIT_LOCK = 2'b01,
        HOLD      = 2'b10,
        RUN       = 2'b11
    } state_t;

    if (SYNC_STAGES < 2 || GLITCH_CYCLES < 1) begin : g_bad_params
        $error("pll_reset_seq: SYNC_STAGES must be >= 2 and GLITCH_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   locked_s;
    logic                   lock_lost;
    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic                   relock_inc;
    logic                   pll_rst_reg, sys_rstn_reg;
    logic [7:0]             relock_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_reg[SYNC_STAGES-1];

`ifdef RESET_SEQ_GLITCH_FILTER_EN
    localparam int GW = $clog2(GLITCH_CYCLES + 1);
    logic [GW-1:0] glitch_reg;

    // Saturates on the last low cycle that is still tolerated; any high sample re-arms it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            glitch_reg <= '0;
        end else if (locked_s) begin
            glitch_reg <= '0;
        end else if (glitch_reg != GW'(GLITCH_CYCLES - 1)) begin
            glitch_reg <= glitch_reg + 1'b1;
        end
    end

    assign lock_lost = !locked_s && (glitch_reg == GW'(GLITCH_CYCLES - 1));
`else
    assign lock_lost = !locked_s;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        relock_inc = 1'b0;
        case (state_reg)
            PLL_RST: begin
                if (cnt_reg == CNT_W'(PLL_RST_CYCLES - 1)) state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = HOLD;
                end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_next = PLL_RST;
                    relock_inc = 1'b1;
                end
            end
            HOLD: begin
                if (lock_lost) state_next = WAIT_LOCK;
                else if (cnt_reg == CNT_W'(HOLD_CYCLES - 1)) state_next = RUN;
            end
            RUN: begin
                cnt_next = '0;
                if (lock_lost) begin
                    state_next = PLL_RST;
                    relock_inc = 1'b1;
                end else if (soft_rst_req) begin
                    state_next = HOLD;
                end
            end
            default: state_next = PLL_RST;
        endcase
        if (state_next != state_reg) cnt_next = '0;
    end

    // Outputs decode the next state so they move on the same edge as state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= PLL_RST;
            cnt_reg      <= '0;
            pll_rst_reg  <= 1'b1;
            sys_rstn_reg <= 1'b0;
            relock_reg   <= 8'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            pll_rst_reg  <= (state_next == PLL_RST);
            sys_rstn_reg <= (state_next == RUN);
            if (relock_inc && relock_reg != 8'hFF) relock_reg <= relock_reg + 8'd1;
        end
    end

    assign state      = state_reg;
    assign pll_rst    = pll_rst_reg;
    assign sys_rstn   = sys_rstn_reg;
    assign relock_cnt = relock_reg;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: expected behaviour is a timeline of (state, duration, relock count) segments.
`timescale 1ns/1ps
module tb_pll_reset_seq;

    localparam int SYNC  = 2;
    localparam int HOLDC = 16;
    localparam int TO    = 100;
    localparam int PR    = 4;
    localparam int GC    = 8;
`ifdef RESET_SEQ_GLITCH_FILTER_EN
    localparam int GL = GC - 1;
`else
    localparam int GL = 0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       pll_rst, sys_rstn;
    logic [1:0] state;
    logic [7:0] relock_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {int len; logic [1:0] st; int rc;} seg_t;
    typedef struct {int at; bit is_soft; logic val;} stim_t;
    seg_t  segs[$];
    stim_t stims[$];

    pll_reset_seq #(
        .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLDC), .LOCK_TIMEOUT(TO),
        .PLL_RST_CYCLES(PR), .GLITCH_CYCLES(GC)
    ) dut (
        .clock(clock), .reset(reset), .locked(locked), .soft_rst_req(soft_rst_req),
        .pll_rst(pll_rst), .sys_rstn(sys_rstn), .state(state), .relock_cnt(relock_cnt)
    );

    always #10 clock = ~clock;

    // Outputs follow from the state: pll_rst only in PLL_RST, sys_rstn only in RUN.
    function automatic logic [11:0] expect_vec(input logic [1:0] st, input int rc);
        return {st, (st == 2'b00), (st == 2'b11), 8'(rc)};
    endfunction

    function automatic int sat(input int rc);
        return (rc < 255) ? rc + 1 : 255;
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed {state,pll_rst,sys_rstn,relock}=%h required %h at %0t",
                     tag, obs, exp, $time);
            $error("%s observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic add(input int len, input logic [1:0] st, input int rc);
        segs.push_back('{len, st, rc});
    endtask

    task automatic stim(input int at, input bit is_soft, input logic val);
        stims.push_back('{at, is_soft, val});
    endtask

    // A stimulus tagged 'at' is applied after edge 'at' and first seen by edge at+1.
    task automatic apply(input int t);
        foreach (stims[k]) begin
            if (stims[k].at == t) begin
                if (stims[k].is_soft) soft_rst_req = stims[k].val;
                else                  locked = stims[k].val;
            end
        end
    endtask

    task automatic play(input string tag);
        int t = 0;
        apply(0);
        foreach (segs[i]) begin
            for (int j = 0; j < segs[i].len; j++) begin
                @(posedge clock);
                t++;
                @(negedge clock);
                check($sformatf("%s@%0d", tag, t), {state, pll_rst, sys_rstn, relock_cnt},
                      expect_vec(segs[i].st, segs[i].rc));
                apply(t);
            end
        end
        $display("step %s: %0d edges, relock_cnt=%0d, state=%b", tag, t, relock_cnt, state);
        segs.delete();
        stims.delete();
    endtask

    initial begin
        int k, s, rc;
        rc = 0;

        repeat (3) @(negedge clock);
        check("reset_values", {state, pll_rst, sys_rstn, relock_cnt}, {2'b00, 1'b1, 1'b0, 8'h00});

        // Lock arrives a random number of cycles after release.
        k = $urandom_range(PR, 40);
        reset = 1'b1;
        stim(k - 1, 0, 1'b1);
        add(PR - 1, 2'b00, rc);
        add(k + 2 - PR, 2'b01, rc);
        add(HOLDC, 2'b10, rc);
        add(5, 2'b11, rc);
        play("lock_up");

        // One-cycle lock dropout in RUN.
        s = $urandom_range(0, 10);
        stim(s, 0, 1'b0);
        stim(s + 1, 0, 1'b1);
`ifdef RESET_SEQ_GLITCH_FILTER_EN
        add(s + 30, 2'b11, rc);
`else
        add(s + SYNC, 2'b11, rc);
        rc = sat(rc);
        add(PR, 2'b00, rc);
        add(1, 2'b01, rc);
        add(HOLDC, 2'b10, rc);
        add(5, 2'b11, rc);
`endif
        play("lock_drop");

        // Soft reset in RUN, plus a second request in HOLD that must be ignored.
        s = $urandom_range(0, 10);
        stim(s, 1, 1'b1);
        stim(s + 1, 1, 1'b0);
        stim(s + 5, 1, 1'b1);
        stim(s + 6, 1, 1'b0);
        add(s, 2'b11, rc);
        add(HOLDC, 2'b10, rc);
        add(5, 2'b11, rc);
        play("soft_rst");

        // Soft request on the very cycle lock loss is seen.
        s = $urandom_range(0, 10);
        stim(s, 0, 1'b0);
        stim(s + 1, 0, 1'b1);
        stim(s + 2, 1, 1'b1);
        stim(s + 3, 1, 1'b0);
`ifdef RESET_SEQ_GLITCH_FILTER_EN
        add(s + 2, 2'b11, rc);
        add(HOLDC, 2'b10, rc);
        add(5, 2'b11, rc);
`else
        add(s + SYNC, 2'b11, rc);
        rc = sat(rc);
        add(PR, 2'b00, rc);
        add(1, 2'b01, rc);
        add(HOLDC, 2'b10, rc);
        add(5, 2'b11, rc);
`endif
        play("soft_vs_loss");

        // Lock gone for good: 300 timeouts drive relock_cnt into saturation.
        stim(0, 0, 1'b0);
        add(SYNC + GL, 2'b11, rc);
        rc = sat(rc);
        add(PR, 2'b00, rc);
        for (int i = 0; i < 300; i++) begin
            add(TO, 2'b01, rc);
            rc = sat(rc);
            add(PR, 2'b00, rc);
        end
        play("timeouts");
        check("relock_saturated", {4'h0, relock_cnt}, 12'd255);

        // Regain lock, then assert reset in the middle of HOLD.
        stim(0, 0, 1'b1);
        add(2, 2'b01, rc);
        add(5, 2'b10, rc);
        play("into_hold");
        #3 reset = 1'b0;
        #1 check("async_reset", {state, pll_rst, sys_rstn, relock_cnt}, {2'b00, 1'b1, 1'b0, 8'h00});
        @(negedge clock);
        check("reset_held", {state, pll_rst, sys_rstn, relock_cnt}, {2'b00, 1'b1, 1'b0, 8'h00});

        // Release with lock already high: sequence restarts with a zero relock count.
        rc = 0;
        reset = 1'b1;
        add(PR - 1, 2'b00, rc);
        add(1, 2'b01, rc);
        add(HOLDC, 2'b10, rc);
        add(5, 2'b11, rc);
        play("restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Reset sequencer on the free-running 50 MHz reference clock, next to the PLL wrapper.
- Drives the PLL `rst` input and consumes its `locked` output.
- Releases the system reset only after lock has been stable for a programmable hold time.
- Re-triggers the PLL on lock loss or lock timeout; `sys_rstn` must be re-synchronised in each PLL output domain by its consumer.

Parameters:
- SYNC_STAGES, 2, flip-flop stages of the `locked` synchroniser (minimum 2).
- HOLD_CYCLES, 1024, cycles `locked` must stay high before `sys_rstn` is released.
- LOCK_TIMEOUT, 1000000, cycles to wait for lock before re-resetting the PLL (20 ms at 50 MHz).
- PLL_RST_CYCLES, 16, width of the `pll_rst` pulse in cycles.
- GLITCH_CYCLES, 8, consecutive low cycles of synchronised `locked` that count as lock loss (optional feature only).

Ports:
- clock  in  1  reference clock, same net as the PLL `refclk`.
- reset  in  1  asynchronous active-low reset.
- locked  in  1  PLL lock indicator, treated as asynchronous.
- soft_rst_req  in  1  single-cycle request to re-apply system reset without resetting the PLL.
- pll_rst  out  1  active-high reset to the PLL.
- sys_rstn  out  1  active-low system reset, synchronous to `clock`.
- state  out  2  current FSM state, for debug.
- relock_cnt  out  8  count of PLL re-resets since `reset`, saturating.

Behaviour:
- Reset values (`reset`=0): state=PLL_RST (00), pll_rst=1, sys_rstn=0, relock_cnt=0, internal counter=0, synchroniser=0.
- Synchroniser: `locked` passes through SYNC_STAGES flops to give `locked_s`; the FSM uses only `locked_s`.
- Counter width is a localparam sized for the largest of HOLD_CYCLES, LOCK_TIMEOUT, PLL_RST_CYCLES.
- Every state entry clears the counter.
- Outputs are registered and decoded from next-state, so they change on the same edge as `state`.
- PLL_RST (00):
  - pll_rst=1, sys_rstn=0.
  - After PLL_RST_CYCLES cycles in this state, go to WAIT_LOCK.
  - After `reset` release, pll_rst stays high for exactly PLL_RST_CYCLES further edges.
- WAIT_LOCK (01):
  - pll_rst=0, sys_rstn=0.
  - locked_s=1 -> HOLD.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1 -> PLL_RST and relock_cnt+1.
  - If locked_s rises on the timeout cycle, HOLD wins.
- HOLD (10):
  - pll_rst=0, sys_rstn=0.
  - locked_s=0 -> WAIT_LOCK (counter restarts; this is not a relock).
  - After HOLD_CYCLES consecutive cycles with locked_s=1 -> RUN.
- RUN (11):
  - pll_rst=0, sys_rstn=1.
  - locked_s=0 -> PLL_RST and relock_cnt+1.
  - soft_rst_req=1 -> HOLD.
  - If both occur in the same cycle, lock loss wins.
- soft_rst_req is ignored outside RUN.
- relock_cnt saturates at 255 and never wraps.
- Latency from `locked` falling in RUN to `sys_rstn`=0: SYNC_STAGES+1 rising edges.
- `reset` asserted at any time forces the reset values asynchronously.
- On `reset` release, the sequence restarts from PLL_RST with relock_cnt=0.

Optional Feature:
- Macro: RESET_SEQ_GLITCH_FILTER_EN.
- With the macro defined:
  - In HOLD and RUN, lock loss is recognised only after GLITCH_CYCLES consecutive cycles of locked_s=0.
  - A dedicated filter counter clears on any locked_s=1.
  - Shorter dropouts are ignored; in HOLD they do not reset the hold count.
  - Lock-loss latency in RUN becomes SYNC_STAGES+GLITCH_CYCLES edges.
- Without the macro:
  - No filter logic is built.
  - Behaviour is exactly as in Behaviour.

Test Plan (sim params HOLD_CYCLES=16, LOCK_TIMEOUT=100, PLL_RST_CYCLES=4, SYNC_STAGES=2):
- Release reset, `locked` rises at cycle 10 -> pll_rst high for edges 1-4; state passes 01 then 10; sys_rstn rises 16 edges after state=10; relock_cnt=0.
- `locked` held low after release -> pll_rst re-pulses 4 cycles every 104 cycles; relock_cnt increments 1, 2, 3 ...; sys_rstn stays 0.
- In RUN, drop `locked` for 1 cycle, macro undefined -> sys_rstn=0 on 3rd edge; pll_rst pulse of 4 cycles; relock_cnt+1.
  - Same stimulus with RESET_SEQ_GLITCH_FILTER_EN and GLITCH_CYCLES=8 -> no change.
- In RUN, pulse soft_rst_req -> state=10, sys_rstn=0 for exactly 16 cycles, pll_rst stays 0, relock_cnt unchanged.
  - soft_rst_req in the same cycle as locked_s falling -> PLL_RST path taken.
- Force 300 timeouts -> relock_cnt saturates at 255.
  - Assert `reset` mid-HOLD -> all outputs return to reset values immediately, no clock edge required.
